// File: rtl/dualportedram_fifo_ctrl_if.sv
// User-side push/pop handshake bundle for the dual-ported RAM FIFO controller.
// The master drives requests; the slave (the controller) returns data and status.
interface dualportedram_fifo_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic          push;
  logic [DW-1:0] pushD;
  logic          full;
  logic          afull;
  logic          pop;
  logic [DW-1:0] popQ;
  logic          popV;
  logic          empty;
  logic [AW:0]   level;
  logic          ovf;
  logic          udf;

  modport master (
    output push, pushD, pop,
    input  full, afull, popQ, popV, empty, level, ovf, udf
  );

  modport slave (
    input  push, pushD, pop,
    output full, afull, popQ, popV, empty, level, ovf, udf
  );
endinterface

// File: rtl/dualportedram_fifo_ctrl.sv
// Single-clock FIFO controller: RAM port A is the write port, port B the read port.
// Pointers, fill level, flags and sticky error bits live here; storage lives in the RAM.
module dualportedram_fifo_ctrl #(
  parameter int DW  = 8,
  parameter int AW  = 6,
  parameter int AFT = 56
) (
  input  logic                 C,
  input  logic                 R,
  dualportedram_fifo_ctrl_if.slave f,
  output logic                 aWR,
  output logic [AW-1:0]        aA,
  output logic [DW-1:0]        aD,
  output logic                 bWR,
  output logic [AW-1:0]        bA,
  input  logic [DW-1:0]        bQ
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(2**AW);
  localparam logic [AW:0]   AFT_L   = (AW+1)'(AFT);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   lvl;
  logic          pop_v;
  logic          ovf_r;
  logic          udf_r;

  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  // Flags decode the registered level only, so they never glitch.
  assign full    = (lvl == DEPTH_L);
  assign empty   = (lvl == '0);
  assign push_ok = f.push & ~full;
  assign pop_ok  = f.pop & ~empty;

  assign aWR = push_ok & ~R;
  assign aA  = wptr;
  assign aD  = f.pushD;
  assign bWR = 1'b0;
  assign bA  = rptr;

  assign f.full  = full;
  assign f.afull = (lvl >= AFT_L);
  assign f.empty = empty;
  assign f.level = lvl;
  assign f.popV  = pop_v;
  assign f.popQ  = bQ;
  assign f.ovf   = ovf_r;
  assign f.udf   = udf_r;

  // NOTE: state updates use <= so every register samples pre-edge values;
  // the RAM itself is not reset, stale words are unreachable once level is 0.
  always_ff @(posedge C) begin
    if (R) begin
      wptr  <= '0;
      rptr  <= '0;
      lvl   <= '0;
      pop_v <= 1'b0;
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   lvl <= lvl + LVL_ONE;
        2'b01:   lvl <= lvl - LVL_ONE;
        default: lvl <= lvl;
      endcase
      pop_v <= pop_ok;
      ovf_r <= ovf_r | (f.push & full);
      udf_r <= udf_r | (f.pop & empty);
    end
  end

endmodule

// File: tb/tb_dualportedram_fifo_ctrl.sv
// Randomised and directed bench for the FIFO controller with a behavioural RAM;
// a queue model predicts flags and pop data, a monitor compares every popV beat.
module tb_dualportedram_fifo_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 6;
  localparam int AFT = 56;
  localparam int DEPTH = 2**AW;

  logic          C = 1'b0;
  logic          R;
  logic          aWR;
  logic [AW-1:0] aA;
  logic [DW-1:0] aD;
  logic          bWR;
  logic [AW-1:0] bA;
  logic [DW-1:0] bQ;

  dualportedram_fifo_ctrl_if #(.DW(DW), .AW(AW)) f ();

  dualportedram_fifo_ctrl #(.DW(DW), .AW(AW), .AFT(AFT)) dut (
    .C   (C),
    .R   (R),
    .f   (f),
    .aWR (aWR),
    .aA  (aA),
    .aD  (aD),
    .bWR (bWR),
    .bA  (bA),
    .bQ  (bQ)
  );

  always #5 C = ~C;

  // Behavioural dual-ported RAM with a registered read port.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge C) begin
    if (aWR) mem[aA] <= aD;
    bQ <= mem[bA];
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_q   [$];
  bit            m_ovf, m_udf, m_popv;
  int            w_idx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every popV beat must carry the oldest predicted word.
  always @(negedge C) begin
    if (f.popV === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none at %0t", f.popQ, $time);
      end else begin
        check("pop_data", {24'd0, f.popQ}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // One clock cycle: drive at negedge, check combinational RAM strobes,
  // advance the model at posedge, check registered outputs at the next negedge.
  task automatic cycle(input bit p, input bit q, input logic [DW-1:0] d, input bit r);
    bit pok, qok;
    int sz;
    f.push  = p;
    f.pop   = q;
    f.pushD = d;
    R       = r;
    sz  = model_q.size();
    pok = p && (sz < DEPTH);
    qok = q && (sz > 0);
    #1;
    check("aWR", {31'd0, aWR}, {31'd0, pok && !r});
    check("bWR", {31'd0, bWR}, 32'd0);
    if (pok && !r) begin
      check("aA", {26'd0, aA}, w_idx % DEPTH);
      check("aD", {24'd0, aD}, {24'd0, d});
    end
    @(posedge C);
    if (r) begin
      model_q.delete();
      exp_q.delete();
      m_ovf  = 0;
      m_udf  = 0;
      m_popv = 0;
      w_idx  = 0;
    end else begin
      if (p && sz == DEPTH) m_ovf = 1;
      if (q && sz == 0)     m_udf = 1;
      if (qok) exp_q.push_back(model_q.pop_front());
      if (pok) begin
        model_q.push_back(d);
        w_idx++;
      end
      m_popv = qok;
    end
    @(negedge C);
    sz = model_q.size();
    check("level", {25'd0, f.level}, sz);
    check("full",  {31'd0, f.full},  {31'd0, sz == DEPTH});
    check("afull", {31'd0, f.afull}, {31'd0, sz >= AFT});
    check("empty", {31'd0, f.empty}, {31'd0, sz == 0});
    check("ovf",   {31'd0, f.ovf},   {31'd0, m_ovf});
    check("udf",   {31'd0, f.udf},   {31'd0, m_udf});
    check("popV",  {31'd0, f.popV},  {31'd0, m_popv});
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h77, 1'b1);
    cycle(1'b1, 1'b1, 8'h78, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    int guard;
    bit p, q;
    int pp, qp;
    f.push = 0; f.pop = 0; f.pushD = '0; R = 1;
    @(negedge C);

    // Reset with push held high: no RAM write during R.
    do_reset();

    // Three pushes then three pops, data in order.
    cycle(1, 0, 8'h11, 0);
    cycle(1, 0, 8'h22, 0);
    cycle(1, 0, 8'h33, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00, 0);
    idle(2);

    // Fill to full, overflow attempt, drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, DW'(i), 0);
    cycle(1, 0, 8'hAA, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00, 0);
    idle(2);

    // Random occupancy across pointer wrap, phases bias fill or drain.
    idx = 0;
    guard = 0;
    while ((idx < 100 || model_q.size() > 0) && guard < 3000) begin
      pp = ((guard / 40) % 2 == 0) ? 75 : 35;
      qp = 100 - pp;
      p = (idx < 100) && ($urandom_range(0, 99) < pp);
      q = ($urandom_range(0, 99) < qp) || (idx >= 100);
      if (p && model_q.size() < DEPTH) begin
        cycle(p, q, DW'((idx * 3) & 8'hFF), 0);
        idx++;
      end else begin
        cycle(p, q, DW'((idx * 3) & 8'hFF), 0);
      end
      guard++;
    end
    check("random_drained", model_q.size(), 0);
    idle(2);

    // Simultaneous push+pop at empty, then at full.
    do_reset();
    cycle(1, 1, 8'h44, 0);
    for (int i = 1; i < DEPTH; i++) cycle(1, 0, DW'(8'h80 + i), 0);
    cycle(1, 1, 8'hBB, 0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(0, 1, 8'h00, 0);
    idle(2);

    // Reset on the cycle after an accepted pop.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, DW'(8'hC0 + i), 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 1);
    idle(1);
    cycle(1, 0, 8'h5A, 0);
    cycle(0, 1, 8'h00, 0);
    idle(3);

    #2;
    check("all_pops_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
